// File: rtl/uart_rx_pkg.sv
// Shared UART types and default bit-timing constants.
// The transmitter and the receiver both use these, so they agree at the same settings.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START_CHECK,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int TICK_FULL_DEF = 837;
    localparam int TICK_HALF_DEF = 418;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial pin, plus a delay flop used to detect falling edges.
// Every flop resets to the idle-high line level, so releasing reset cannot create a false edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall_edge
);

    logic meta_q;
    logic rx_s_q;
    logic rx_d_q;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
        end else begin
            meta_q <= i_rx;
            rx_s_q <= meta_q;
            rx_d_q <= rx_s_q;
        end
    end

    assign o_rx_s      = rx_s_q;
    assign o_fall_edge = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The start bit is checked again at mid-bit, then each bit is sampled
// once per bit period. A good byte gives a one-cycle valid strobe; a low stop bit gives a frame-error strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int TICK_FULL = TICK_FULL_DEF,
    parameter int TICK_HALF = TICK_HALF_DEF
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       i_rx_serial,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_busy,
    output logic       o_frame_err,
    output logic       o_tick_debug
);

    localparam int CW = $clog2(TICK_FULL + 1);
    localparam logic [CW-1:0] FULL = CW'(TICK_FULL);
    localparam logic [CW-1:0] HALF = CW'(TICK_HALF);

    logic rx_s;
    logic fall_edge;

    uart_rx_sync u_sync (
        .i_clk       (i_clk),
        .rst         (rst),
        .i_rx        (i_rx_serial),
        .o_rx_s      (rx_s),
        .o_fall_edge (fall_edge)
    );

    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          busy_q;
    logic          err_q;
    logic          tick_q;

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    // A line that is already low (break, stuck-low) never starts a frame.
                    // Only a high-to-low transition does.
                    if (fall_edge) begin
                        state_q <= RX_START_CHECK;
                        busy_q  <= 1'b1;
                    end
                end
                RX_START_CHECK: begin
                    if (cnt_q == HALF) begin
                        tick_q <= 1'b1;
                        cnt_q  <= '0;
                        if (!rx_s) begin
                            state_q <= RX_DATA;
                        end else begin
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL) begin
                        tick_q         <= 1'b1;
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == 3'd7) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Return to idle at mid-stop-bit, so a start edge that follows
                    // immediately is still caught.
                    if (cnt_q == FULL) begin
                        tick_q  <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= RX_IDLE;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign o_rx_data    = data_q;
    assign o_rx_valid   = valid_q;
    assign o_rx_busy    = busy_q;
    assign o_frame_err  = err_q;
    assign o_tick_debug = tick_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (bit = 16 clocks) and a full-rate instance (bit = 838 clocks).
// Both are fed by a behavioural 8N1 transmitter.
module tb_uart_rx;

    localparam int BIT      = 16;
    localparam int BIT_LB   = 838;
    localparam int BUSY_CYC = 7 + 9 * 16 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx2;
    logic [7:0] data, data2;
    logic       valid, busy, err, tick;
    logic       valid2, busy2, err2, tick2;

    always #5 clk = ~clk;

    uart_rx #(.TICK_FULL(15), .TICK_HALF(7)) dut (
        .i_clk(clk), .rst(rst), .i_rx_serial(rx),
        .o_rx_data(data), .o_rx_valid(valid), .o_rx_busy(busy),
        .o_frame_err(err), .o_tick_debug(tick)
    );

    uart_rx #(.TICK_FULL(837), .TICK_HALF(418)) dut_lb (
        .i_clk(clk), .rst(rst), .i_rx_serial(rx2),
        .o_rx_data(data2), .o_rx_valid(valid2), .o_rx_busy(busy2),
        .o_frame_err(err2), .o_tick_debug(tick2)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Activity monitor. It only counts what it sees; the test tasks compare the counts.
    int         cyc = 0, vcnt = 0, ecnt = 0, bcnt = 0, tcnt = 0, bad = 0;
    int         last_vcyc = 0, prev_vcyc = 0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;
    logic       strobe_prev = 1'b0;
    int         lb_n = 0, lb_err = 0;
    logic [7:0] lb_log [4];

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        strobe_prev <= valid | err;
        if (valid) begin
            vcnt      <= vcnt + 1;
            prev_data <= last_data;
            last_data <= data;
            prev_vcyc <= last_vcyc;
            last_vcyc <= cyc;
        end
        if (err)  ecnt <= ecnt + 1;
        if (busy) bcnt <= bcnt + 1;
        if (tick) tcnt <= tcnt + 1;
        if ((valid && err) || ((valid || err) && strobe_prev)) bad <= bad + 1;
        if (valid2) begin
            if (lb_n < 4) lb_log[lb_n] <= data2;
            lb_n <= lb_n + 1;
        end
        if (err2) lb_err <= lb_err + 1;
    end

    task automatic drive(input logic v, input int n, input bit lb);
        if (lb) rx2 = v; else rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int per, input bit lb);
        drive(1'b0, per, lb);
        for (int i = 0; i < 8; i++) drive(b[i], per, lb);
        drive(stop, per, lb);
    endtask

    task automatic test_reset();
        #1;
        n_chk += 5;
        if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        if (tick !== 1'b0)  begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        int v0, e0, b0, t0;
        v0 = vcnt; e0 = ecnt; b0 = bcnt; t0 = tcnt;
        send(8'hA5, 1'b1, BIT, 1'b0);
        drive(1'b1, 20, 1'b0);
        n_chk += 5;
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_count got %0d want 1", vcnt - v0); end
        if (data !== 8'hA5)  begin n_fail++; $display("FAIL a5_data got %h want a5", data); end
        if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL a5_err_count got %0d want 0", ecnt - e0); end
        if (bcnt - b0 !== BUSY_CYC) begin n_fail++; $display("FAIL a5_busy_cycles got %0d want %0d", bcnt - b0, BUSY_CYC); end
        if (tcnt - t0 !== 10) begin n_fail++; $display("FAIL a5_ticks got %0d want 10", tcnt - t0); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = vcnt;
        send(8'h00, 1'b1, BIT, 1'b0);
        send(8'hFF, 1'b1, BIT, 1'b0);
        drive(1'b1, 20, 1'b0);
        n_chk += 4;
        if (vcnt - v0 !== 2)      begin n_fail++; $display("FAIL b2b_count got %0d want 2", vcnt - v0); end
        if (prev_data !== 8'h00)  begin n_fail++; $display("FAIL b2b_first got %h want 00", prev_data); end
        if (last_data !== 8'hFF)  begin n_fail++; $display("FAIL b2b_second got %h want ff", last_data); end
        if (last_vcyc - prev_vcyc !== 160) begin n_fail++; $display("FAIL b2b_spacing got %0d want 160", last_vcyc - prev_vcyc); end
    endtask

    task automatic test_glitch();
        int v0, e0, b0, t0;
        v0 = vcnt; e0 = ecnt; b0 = bcnt; t0 = tcnt;
        drive(1'b0, 3, 1'b0);
        drive(1'b1, 30, 1'b0);
        n_chk += 5;
        if (bcnt - b0 !== 8) begin n_fail++; $display("FAIL glitch_busy_cycles got %0d want 8", bcnt - b0); end
        if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", vcnt - v0); end
        if (ecnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_err got %0d want 0", ecnt - e0); end
        if (tcnt - t0 !== 1) begin n_fail++; $display("FAIL glitch_ticks got %0d want 1", tcnt - t0); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL glitch_idle got %b want 0", busy); end
    endtask

    task automatic test_frame_err();
        int v0, e0, b0;
        v0 = vcnt; e0 = ecnt; b0 = bcnt;
        send(8'h3C, 1'b0, BIT, 1'b0);
        drive(1'b0, 200, 1'b0);
        n_chk += 4;
        if (ecnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", ecnt - e0); end
        if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid got %0d want 0", vcnt - v0); end
        if (data !== 8'hFF)  begin n_fail++; $display("FAIL ferr_data_kept got %h want ff", data); end
        if (bcnt - b0 !== BUSY_CYC) begin n_fail++; $display("FAIL ferr_low_line_busy got %0d want %0d", bcnt - b0, BUSY_CYC); end
        drive(1'b1, 20, 1'b0);
    endtask

    task automatic test_mid_reset();
        int v0;
        logic [7:0] b;
        b = 8'h5A;
        drive(1'b0, BIT, 1'b0);
        for (int i = 0; i < 4; i++) drive(b[i], BIT, 1'b0);
        drive(b[4], 8, 1'b0);
        rx  = 1'b1;
        rst = 1'b1;
        #1;
        n_chk += 5;
        if (data !== 8'h00) begin n_fail++; $display("FAIL mrst_data got %h want 00", data); end
        if (valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got %b want 0", valid); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL mrst_busy got %b want 0", busy); end
        if (err !== 1'b0)   begin n_fail++; $display("FAIL mrst_err got %b want 0", err); end
        if (tick !== 1'b0)  begin n_fail++; $display("FAIL mrst_tick got %b want 0", tick); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 10, 1'b0);
        v0 = vcnt;
        send(8'h81, 1'b1, BIT, 1'b0);
        drive(1'b1, 20, 1'b0);
        n_chk += 2;
        if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL mrst_81_count got %0d want 1", vcnt - v0); end
        if (data !== 8'h81)  begin n_fail++; $display("FAIL mrst_81_data got %h want 81", data); end
    endtask

    task automatic test_loopback();
        logic [7:0] exp [4];
        exp[0] = 8'h00; exp[1] = 8'h55; exp[2] = 8'hC3; exp[3] = 8'hFF;
        for (int i = 0; i < 4; i++) send(exp[i], 1'b1, BIT_LB, 1'b1);
        drive(1'b1, 200, 1'b1);
        n_chk += 2;
        if (lb_n !== 4)   begin n_fail++; $display("FAIL lb_count got %0d want 4", lb_n); end
        if (lb_err !== 0) begin n_fail++; $display("FAIL lb_frame_err got %0d want 0", lb_err); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= lb_n || lb_log[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL lb_byte%0d got %h want %h", i, lb_log[i], exp[i]);
            end
        end
    endtask

    task automatic test_strobe_rules();
        n_chk++;
        if (bad !== 0) begin n_fail++; $display("FAIL strobe_overlap got %0d want 0", bad); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        rx2 = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_mid_reset();
        test_loopback();
        test_strobe_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Receives an asynchronous 8N1 serial byte stream (idle high, start low, 8 data bits LSB first, stop high) and presents each byte on a parallel port with a one-cycle valid strobe. Sits downstream of the UART transmitter, either on the far end of the link or in loopback. Bit timing comes from a clock-tick counter of the same form as the transmitter, so the two blocks interoperate at the same parameter values. Sampling is at mid-bit after start-bit validation.

Parameters:
TICK_FULL, 837, last count value of one bit period; bit period = TICK_FULL+1 clocks
TICK_HALF, 418, count value at which the start bit is re-checked (mid start bit); must be < TICK_FULL

Ports:
i_clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_rx_serial  in  1  asynchronous serial line, idle high
o_rx_data  out  8  last correctly framed byte; holds until next good byte
o_rx_valid  out  1  one-cycle pulse: o_rx_data updated
o_rx_busy  out  1  high from validated start edge until frame end
o_frame_err  out  1  one-cycle pulse: stop bit sampled low
o_tick_debug  out  1  one-cycle pulse on every sample point

Behaviour:
- Reset, asynchronous, active-high. Every state element returns to reset value immediately, including mid-frame: state IDLE, counter 0, bit index 0, shift register 0x00, synchronizer flops 1, o_rx_data 0x00, o_rx_valid 0, o_rx_busy 0, o_frame_err 0, o_tick_debug 0. A partial frame is discarded with no strobe.
- Input conditioning: i_rx_serial passes a 2-flop synchronizer (rx_s). A third flop (rx_d) holds the previous rx_s for edge detection. All FSM decisions use rx_s only.
- FSM states:
  - IDLE: counter 0, bit index 0. Falling edge (rx_d=1, rx_s=0) -> START_CHECK, counter cleared, o_rx_busy 1 next cycle. A line already low with no preceding high, such as a break or stuck-low, never starts a frame.
  - START_CHECK: increment counter until it equals TICK_HALF. At TICK_HALF, pulse o_tick_debug. If rx_s=0 -> DATA, counter 0. If rx_s=1 -> IDLE as a glitch reject: busy drops, no valid, no err.
  - DATA: increment counter until it equals TICK_FULL. At TICK_FULL, pulse o_tick_debug, shift rx_s into bit[bit index] (LSB first), counter 0, bit index +1. After the 8th sample (index 7) -> STOP.
  - STOP: at TICK_FULL, pulse o_tick_debug and sample rx_s.
    - rx_s=1: o_rx_data <= shift register; o_rx_valid pulses 1 cycle.
    - rx_s=0: o_frame_err pulses 1 cycle; o_rx_data unchanged.
    - Either case: -> IDLE, o_rx_busy 0 in the same cycle the strobe is high.
- Timing:
  - Sample k (k=0 start re-check, 1..8 data, 9 stop) occurs TICK_HALF + k*(TICK_FULL+1) clocks after the edge-detect cycle.
  - The strobe is registered and appears the cycle after the stop sample.
  - Total from edge detect to strobe = TICK_HALF + 9*(TICK_FULL+1) + 1 clocks, plus 2 synchronizer cycles from the pin.
- o_rx_valid and o_frame_err are never high together, and are never high for 2 consecutive cycles.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving half a bit later is caught. No idle gap is required.
- Counter width is $clog2(TICK_FULL+1). The counter never wraps; it compares for equality and clears.
- There is no backpressure. The consumer must take o_rx_data on o_rx_valid. A new good byte overwrites the previous one.

Decomposition:
- Shared package typedefs: add rx_state_t enum {RX_IDLE, RX_START_CHECK, RX_DATA, RX_STOP}, alongside the existing transmitter state type. Add default tick constants there so TX and RX share them.
- One sub-module is natural: uart_rx_sync. It holds the 2-flop synchronizer plus the edge-detect flop, resets to 1, and outputs rx_s and fall_edge.

Test Plan:
- Bench parameters TICK_FULL=15, TICK_HALF=7. Drive frame 0xA5 -> o_rx_valid one pulse, o_rx_data=0xA5, o_frame_err never 1, busy high for 7+9*16+1 clocks.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two valid pulses 160 clocks apart, data 0x00 then 0xFF.
- Low glitch of 3 clocks on idle line -> busy pulses then drops at the start re-check, no valid, no err, FSM in IDLE.
- Frame 0x3C with stop bit driven low -> o_frame_err one pulse, o_rx_valid 0, o_rx_data keeps previous value 0xFF; line then held low -> no new frame until line returns high and falls again.
- Assert rst during data bit 4 of 0x5A -> all outputs at reset values immediately; after release, frame 0x81 -> valid pulse with 0x81.
- Loopback from the team's UART transmitter, both at TICK_FULL=837: send 0x00, 0x55, 0xC3, 0xFF -> identical bytes received in order, no frame errors.
